// File: rtl/regfile_pc_stack.sv
// Register file with a program counter aliased onto one register and a hardware return stack.
// Optional build macro ZERO_REG_EN: register 0 is hardwired to zero.
module regfile_pc_stack #(
    parameter int WIDTH       = 16,
    parameter int NUM_REGS    = 16,
    parameter int SELW        = $clog2(NUM_REGS),
    parameter int PC_INDEX    = 15,
    parameter int STACK_DEPTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             pc_increment,
    input  logic                             call,
    input  logic                             ret,
    input  logic [WIDTH-1:0]                 call_target,
    input  logic [SELW-1:0]                  rd_a_sel,
    input  logic [SELW-1:0]                  rd_b_sel,
    output logic [WIDTH-1:0]                 rd_a_data,
    output logic [WIDTH-1:0]                 rd_b_data,
    input  logic                             wr_en,
    input  logic [SELW-1:0]                  wr_sel,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             wr_overflow,
    output logic [WIDTH-1:0]                 pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_error,
    output logic [NUM_REGS-1:0]              signflag,
    output logic [NUM_REGS-1:0]              zeroflag,
    output logic [NUM_REGS-1:0]              overflow,
    output logic [NUM_REGS*WIDTH-1:0]        registers
);

    localparam int CNTW = $clog2(STACK_DEPTH + 1);
    localparam int PTRW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [WIDTH-1:0] regs  [NUM_REGS];
    logic [WIDTH-1:0] stack [STACK_DEPTH];
    logic [CNTW-1:0]  count;
    logic [PTRW-1:0]  push_ptr;
    logic [PTRW-1:0]  pop_ptr;
    logic [WIDTH-1:0] pc_cur;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] pc_next;
    logic             stack_full;
    logic             stack_empty;
    logic             do_push;
    logic             do_pop;
    logic             err_set;
    logic             wr_active;

    assign pc_cur      = regs[PC_INDEX];
    assign pc_plus1    = pc_cur + WIDTH'(1);
    assign stack_full  = (count == CNTW'(STACK_DEPTH));
    assign stack_empty = (count == '0);
    assign push_ptr    = count[PTRW-1:0];
    assign pop_ptr     = push_ptr - PTRW'(1);
    assign do_push     = call && !ret && !stack_full;
    assign do_pop      = ret && !call && !stack_empty;
    assign err_set     = (call && ret) || (call && stack_full) || (ret && stack_empty);
    assign wr_active   = wr_en && !(ZERO_REG && (wr_sel == '0));

    // PC from the stack/increment path; a write to PC_INDEX overrides it below.
    always_comb begin
        pc_next = pc_cur;
        if (do_push)
            pc_next = call_target;
        else if (do_pop)
            pc_next = stack[pop_ptr];
        else if (call || ret)
            pc_next = pc_cur;
        else if (pc_increment)
            pc_next = pc_plus1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            count       <= '0;
            stack_error <= 1'b0;
            signflag    <= '0;
            zeroflag    <= '1;
            overflow    <= '0;
        end else begin
            regs[PC_INDEX] <= pc_next;
            if (do_push) begin
                stack[push_ptr] <= pc_plus1;
                count           <= count + CNTW'(1);
            end else if (do_pop) begin
                count <= count - CNTW'(1);
            end
            if (err_set)
                stack_error <= 1'b1;
            if (wr_active) begin
                regs[wr_sel]     <= wr_data;
                signflag[wr_sel] <= wr_data[WIDTH-1];
                zeroflag[wr_sel] <= (wr_data == '0);
                overflow[wr_sel] <= wr_overflow;
            end
        end
    end

    assign rd_a_data   = regs[rd_a_sel];
    assign rd_b_data   = regs[rd_b_sel];
    assign pc          = pc_cur;
    assign stack_count = count;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign registers[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_regfile_pc_stack.sv
// Self-checking bench for regfile_pc_stack: directed scenarios plus randomized traffic
// against a queue-based reference model of the register file and return stack.
module tb_regfile_pc_stack;

    localparam int W   = 16;
    localparam int N   = 16;
    localparam int PCI = 15;
    localparam int D   = 8;
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           pc_increment;
    logic           call;
    logic           ret;
    logic [W-1:0]   call_target;
    logic [3:0]     rd_a_sel;
    logic [3:0]     rd_b_sel;
    logic [W-1:0]   rd_a_data;
    logic [W-1:0]   rd_b_data;
    logic           wr_en;
    logic [3:0]     wr_sel;
    logic [W-1:0]   wr_data;
    logic           wr_overflow;
    logic [W-1:0]   pc;
    logic [3:0]     stack_count;
    logic           stack_error;
    logic [N-1:0]   signflag;
    logic [N-1:0]   zeroflag;
    logic [N-1:0]   overflow;
    logic [N*W-1:0] registers;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] m_regs [N];
    logic [N-1:0] m_sign;
    logic [N-1:0] m_zero;
    logic [N-1:0] m_ovf;
    logic [W-1:0] m_stack [$];
    logic         m_err;
    logic [W-1:0] exp_q [$];

    regfile_pc_stack dut (
        .clock(clock), .reset(reset), .pc_increment(pc_increment), .call(call), .ret(ret),
        .call_target(call_target), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .wr_overflow(wr_overflow), .pc(pc), .stack_count(stack_count),
        .stack_error(stack_error), .signflag(signflag), .zeroflag(zeroflag),
        .overflow(overflow), .registers(registers)
    );

    always #5 clock = ~clock;

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [W-1:0] next_pc;
        if (reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_sign = '0; m_zero = '1; m_ovf = '0; m_err = 1'b0;
            m_stack.delete();
            return;
        end
        next_pc = m_regs[PCI];
        if (call && ret) begin
            m_err = 1'b1;
        end else if (call) begin
            if (m_stack.size() == D) m_err = 1'b1;
            else begin
                m_stack.push_back(m_regs[PCI] + 16'd1);
                next_pc = call_target;
            end
        end else if (ret) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else next_pc = m_stack.pop_back();
        end else if (pc_increment) begin
            next_pc = m_regs[PCI] + 16'd1;
        end
        m_regs[PCI] = next_pc;
        if (wr_en && !(ZR && wr_sel == 4'd0)) begin
            m_regs[wr_sel] = wr_data;
            m_sign[wr_sel] = wr_data[W-1];
            m_zero[wr_sel] = (wr_data == '0);
            m_ovf[wr_sel]  = wr_overflow;
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; pc_increment = 1'b0; call = 1'b0; ret = 1'b0; call_target = '0;
        wr_en = 1'b0; wr_sel = '0; wr_data = '0; wr_overflow = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_a_sel = '0; rd_b_sel = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        n_checks++;
        if (registers !== '0) begin n_fail++; $display("FAIL reset_regs got=%h exp=0", registers); end
        n_checks++;
        if (zeroflag !== 16'hFFFF) begin n_fail++; $display("FAIL reset_zero got=%h exp=ffff", zeroflag); end
        n_checks++;
        if (signflag !== 16'h0000 || overflow !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sign_ovf got=%h/%h exp=0/0", signflag, overflow);
        end
        n_checks++;
        if (stack_count !== 4'd0 || stack_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_stack got=%0d/%b exp=0/0", stack_count, stack_error);
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        wr_en = 1'b1; wr_sel = 4'd7; wr_data = 16'h8002; wr_overflow = 1'b1; rd_b_sel = 4'd7;
        #1;
        n_checks++;
        if (rd_b_data !== 16'h0000) begin n_fail++; $display("FAIL write_old_value got=%h exp=0000", rd_b_data); end
        tick();
        idle_inputs();
        rd_a_sel = 4'd7;
        #1;
        n_checks++;
        if (rd_a_data !== 16'h8002) begin n_fail++; $display("FAIL write_read got=%h exp=8002", rd_a_data); end
        n_checks++;
        if ({signflag[7], zeroflag[7], overflow[7]} !== 3'b101) begin
            n_fail++; $display("FAIL write_flags got=%b%b%b exp=101", signflag[7], zeroflag[7], overflow[7]);
        end
    endtask

    task automatic test_pc_increment();
        idle_inputs();
        pc_increment = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (pc !== 16'h0003) begin n_fail++; $display("FAIL pc_inc3 got=%h exp=0003", pc); end
        wr_en = 1'b1; wr_sel = 4'd15; wr_data = 16'hFFFF;
        tick();
        n_checks++;
        if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL pc_write_prio got=%h exp=ffff", pc); end
        n_checks++;
        if (signflag[15] !== 1'b1 || zeroflag[15] !== 1'b0) begin
            n_fail++; $display("FAIL pc_write_flags got=%b%b exp=10", signflag[15], zeroflag[15]);
        end
        wr_en = 1'b0;
        tick();
        n_checks++;
        if (pc !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap got=%h exp=0000", pc); end
        idle_inputs();
    endtask

    task automatic test_call_ret();
        idle_inputs();
        wr_en = 1'b1; wr_sel = 4'd15; wr_data = 16'h0010;
        tick();
        idle_inputs();
        call = 1'b1; call_target = 16'h0100;
        tick();
        n_checks++;
        if (pc !== 16'h0100 || stack_count !== 4'd1) begin
            n_fail++; $display("FAIL call got=%h/%0d exp=0100/1", pc, stack_count);
        end
        idle_inputs();
        ret = 1'b1;
        tick();
        n_checks++;
        if (pc !== 16'h0011 || stack_count !== 4'd0 || stack_error !== 1'b0) begin
            n_fail++; $display("FAIL ret got=%h/%0d/%b exp=0011/0/0", pc, stack_count, stack_error);
        end
        idle_inputs();
    endtask

    task automatic test_stack_limits();
        logic [W-1:0] exp_pc;
        idle_inputs();
        for (int i = 0; i < 9; i++) begin
            call = 1'b1; call_target = 16'h0200 + 16'(i);
            tick();
        end
        n_checks++;
        if (stack_count !== 4'd8 || pc !== 16'h0207 || stack_error !== 1'b1) begin
            n_fail++; $display("FAIL push_full got=%0d/%h/%b exp=8/0207/1", stack_count, pc, stack_error);
        end
        idle_inputs();
        for (int k = 1; k <= 9; k++) begin
            ret = 1'b1;
            tick();
            exp_pc = (k < 8) ? 16'h0200 + 16'(8 - k) : 16'h0012;
            n_checks++;
            if (pc !== exp_pc || stack_count !== 4'((k < 8) ? 8 - k : 0)) begin
                n_fail++; $display("FAIL pop_%0d got=%h/%0d exp=%h", k, pc, stack_count, exp_pc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_call_ret_same();
        idle_inputs();
        reset = 1'b1;
        tick();
        idle_inputs();
        call = 1'b1; call_target = 16'h0040;
        tick();
        ret = 1'b1;
        tick();
        n_checks++;
        if (pc !== 16'h0040 || stack_count !== 4'd1 || stack_error !== 1'b1) begin
            n_fail++; $display("FAIL call_ret_same got=%h/%0d/%b exp=0040/1/1", pc, stack_count, stack_error);
        end
        ret = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (pc !== 16'h0000 || stack_count !== 4'd0 || stack_error !== 1'b0 || registers !== '0) begin
            n_fail++; $display("FAIL reset_mid_call got=%h/%0d/%b exp=0000/0/0", pc, stack_count, stack_error);
        end
        idle_inputs();
        wr_en = 1'b1; wr_sel = 4'd15; wr_data = 16'h0055; call = 1'b1; call_target = 16'h0099;
        tick();
        n_checks++;
        if (pc !== 16'h0055 || stack_count !== 4'd1) begin
            n_fail++; $display("FAIL write_over_call got=%h/%0d exp=0055/1", pc, stack_count);
        end
        idle_inputs();
        ret = 1'b1;
        tick();
        n_checks++;
        if (pc !== 16'h0001) begin n_fail++; $display("FAIL ret_after_write got=%h exp=0001", pc); end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        wr_en = 1'b1; wr_sel = 4'd0; wr_data = 16'h1234;
        tick();
        idle_inputs();
        rd_a_sel = 4'd0;
        #1;
        n_checks++;
        if (rd_a_data !== (ZR ? 16'h0000 : 16'h1234) || zeroflag[0] !== ZR) begin
            n_fail++; $display("FAIL zero_reg got=%h/%b exp=%h/%b", rd_a_data, zeroflag[0],
                               ZR ? 16'h0000 : 16'h1234, ZR);
        end
    endtask

    task automatic test_random();
        logic [N*W-1:0] exp_bus;
        logic [W-1:0]   exp_pc;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            reset        = ($urandom_range(0, 79) == 0);
            pc_increment = $urandom_range(0, 1);
            call         = ($urandom_range(0, 4) == 0);
            ret          = ($urandom_range(0, 4) == 0);
            call_target  = W'($urandom);
            wr_en        = ($urandom_range(0, 2) == 0);
            wr_sel       = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, N - 1));
            wr_data      = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
            wr_overflow  = $urandom_range(0, 1);
            rd_a_sel     = 4'($urandom_range(0, N - 1));
            rd_b_sel     = 4'($urandom_range(0, N - 1));
            model_step();
            exp_q.push_back(m_regs[PCI]);
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) exp_bus[i*W +: W] = m_regs[i];
            exp_pc = exp_q.pop_front();
            n_checks++;
            if (pc !== exp_pc || registers !== exp_bus) begin
                n_fail++; $display("FAIL rand_regs cyc=%0d pc got=%h exp=%h", c, pc, exp_pc);
            end
            n_checks++;
            if (signflag !== m_sign || zeroflag !== m_zero || overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_flags cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c,
                                   signflag, zeroflag, overflow, m_sign, m_zero, m_ovf);
            end
            n_checks++;
            if (stack_count !== 4'(m_stack.size()) || stack_error !== m_err) begin
                n_fail++; $display("FAIL rand_stack cyc=%0d got=%0d/%b exp=%0d/%b", c,
                                   stack_count, stack_error, m_stack.size(), m_err);
            end
            n_checks++;
            if (rd_a_data !== m_regs[rd_a_sel] || rd_b_data !== m_regs[rd_b_sel]) begin
                n_fail++; $display("FAIL rand_read cyc=%0d got=%h/%h exp=%h/%h", c,
                                   rd_a_data, rd_b_data, m_regs[rd_a_sel], m_regs[rd_b_sel]);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_pc_increment();
        test_call_ret();
        test_stack_limits();
        test_call_ret_same();
        test_zero_reg();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
